// File: rtl/el2_dec_epmp_ctl.sv
// PMP/ePMP CSR state for the decode/TLU path: pmpcfg, pmpaddr and mseccfg with
// lock rules and WARL legalisation, plus the combinational CSR read mux.
module el2_dec_epmp_ctl #(
  parameter int PMP_ENTRIES = 16,
  parameter int PMP_GRAN    = 0,
  parameter int PHYS_ADDR_W = 32,
  parameter int SMEPMP_EN   = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           dec_csr_wen_r_mod,
  input  logic [11:0]                                    dec_csr_wraddr_r,
  input  logic [31:0]                                    dec_csr_wrdata_r,
  input  logic [11:0]                                    dec_csr_rdaddr_d,
  output logic                                           dec_pmp_read_d,
  output logic [31:0]                                    dec_pmp_rddata_d,
  output logic [8*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0]  pmp_pmpcfg,
  output logic [32*((PMP_ENTRIES > 0) ? PMP_ENTRIES : 1)-1:0] pmp_pmpaddr,
  output logic [2:0]                                     pmp_mseccfg,
  output logic                                           pmp_update,
  output logic [6:0]                                     pmp_locked_cnt
);
  localparam int NE  = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
  localparam int AW  = PHYS_ADDR_W - 2;
  localparam int GM1 = (PMP_GRAN >= 1) ? PMP_GRAN - 1 : 0;
  localparam logic [31:0] NAPOT_ONES = (PMP_GRAN >= 2) ? ((32'd1 << GM1) - 32'd1) : 32'd0;
  localparam logic [31:0] GRAN_ZEROS = (PMP_GRAN >= 2) ? ((32'd1 << PMP_GRAN) - 32'd1) : 32'd0;
  localparam logic [1:0] A_OFF = 2'd0, A_TOR = 2'd1, A_NA4 = 2'd2, A_NAPOT = 2'd3;

  logic [NE-1:0][7:0]    cfg_q, cfg_d;
  logic [NE-1:0][AW-1:0] addr_q, addr_d;
  logic                  mml_q, mml_d, mmwp_q, mmwp_d, rlb_q, rlb_d;
  logic                  update_q;
  logic [6:0]            locked_cnt_q, locked_cnt_d;
  logic [NE-1:0]         lk, tor_lk, tor_above;
  logic                  any_l, changed;
  logic                  wr_cfg, wr_addr, wr_sec;
  logic                  rd_cfg, rd_addr, rd_sec;
  logic [5:0]            wr_idx, rd_idx;
  logic [7:0]            cfg_new;

  assign wr_cfg  = dec_csr_wen_r_mod && (dec_csr_wraddr_r[11:4] == 8'h3A);
  assign wr_addr = dec_csr_wen_r_mod && (dec_csr_wraddr_r >= 12'h3B0) && (dec_csr_wraddr_r <= 12'h3EF);
  assign wr_sec  = dec_csr_wen_r_mod && (dec_csr_wraddr_r == 12'h747) && (SMEPMP_EN != 0);
  assign wr_idx  = dec_csr_wraddr_r[5:0] - 6'h30;

  assign rd_cfg  = dec_csr_rdaddr_d[11:4] == 8'h3A;
  assign rd_addr = (dec_csr_rdaddr_d >= 12'h3B0) && (dec_csr_rdaddr_d <= 12'h3EF);
  assign rd_sec  = dec_csr_rdaddr_d == 12'h747;
  assign rd_idx  = dec_csr_rdaddr_d[5:0] - 6'h30;
  assign dec_pmp_read_d = rd_cfg || rd_addr || rd_sec || (dec_csr_rdaddr_d == 12'h757);

  always_comb begin
    any_l  = 1'b0;
    lk     = '0;
    tor_lk = '0;
    for (int i = 0; i < NE; i++) begin
      if (i < PMP_ENTRIES) begin
        lk[i]     = cfg_q[i][7] & ~rlb_q;
        tor_lk[i] = lk[i] & (cfg_q[i][4:3] == A_TOR);
        any_l     = any_l | cfg_q[i][7];
      end
    end
  end

  // A locked TOR entry also protects the pmpaddr below it (its base address)
  assign tor_above = tor_lk >> 1;

  always_comb begin
    cfg_d        = cfg_q;
    addr_d       = addr_q;
    mml_d        = mml_q;
    mmwp_d       = mmwp_q;
    rlb_d        = rlb_q;
    cfg_new      = '0;
    locked_cnt_d = '0;
    for (int i = 0; i < NE; i++) begin
      if (i < PMP_ENTRIES) begin
        cfg_new      = dec_csr_wrdata_r[8*(i%4) +: 8];
        cfg_new[6:5] = 2'b00;
        if (PMP_GRAN >= 1 && cfg_new[4:3] == A_NA4)
          cfg_new[4:3] = A_OFF;
        // W without R is reserved unless MML gives it a meaning
        if (wr_cfg && (dec_csr_wraddr_r[3:0] == 4'(i/4)) && !lk[i] &&
            !(cfg_new[1] && !cfg_new[0] && !(mml_q && SMEPMP_EN != 0)))
          cfg_d[i] = cfg_new;
        if (wr_addr && (wr_idx == 6'(i)) && !lk[i] && !tor_above[i])
          addr_d[i] = dec_csr_wrdata_r[AW-1:0];
      end
      locked_cnt_d = locked_cnt_d + 7'(cfg_d[i][7]);
    end
    if (wr_sec) begin
      mml_d  = mml_q | dec_csr_wrdata_r[0];
      mmwp_d = mmwp_q | dec_csr_wrdata_r[1];
      if (rlb_q || !any_l)
        rlb_d = dec_csr_wrdata_r[2];
    end
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q) ||
                   ({mml_d, mmwp_d, rlb_d} != {mml_q, mmwp_q, rlb_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q        <= '0;
      addr_q       <= '0;
      mml_q        <= 1'b0;
      mmwp_q       <= 1'b0;
      rlb_q        <= 1'b0;
      update_q     <= 1'b0;
      locked_cnt_q <= '0;
    end else begin
      cfg_q        <= cfg_d;
      addr_q       <= addr_d;
      mml_q        <= mml_d;
      mmwp_q       <= mmwp_d;
      rlb_q        <= rlb_d;
      update_q     <= changed;
      locked_cnt_q <= locked_cnt_d;
    end
  end

  always_comb begin
    dec_pmp_rddata_d = '0;
    for (int i = 0; i < NE; i++) begin
      if (i < PMP_ENTRIES) begin
        if (rd_cfg && (dec_csr_rdaddr_d[3:0] == 4'(i/4)))
          dec_pmp_rddata_d[8*(i%4) +: 8] = cfg_q[i];
        if (rd_addr && (rd_idx == 6'(i))) begin
          dec_pmp_rddata_d = 32'(addr_q[i]);
          if (cfg_q[i][4:3] == A_NAPOT)
            dec_pmp_rddata_d = dec_pmp_rddata_d | NAPOT_ONES;
          else if (!cfg_q[i][4])
            dec_pmp_rddata_d = dec_pmp_rddata_d & ~GRAN_ZEROS;
        end
      end
    end
    if (rd_sec)
      dec_pmp_rddata_d = {29'd0, rlb_q, mmwp_q, mml_q};
  end

  always_comb begin
    pmp_pmpaddr = '0;
    for (int i = 0; i < NE; i++)
      pmp_pmpaddr[32*i +: 32] = 32'(addr_q[i]);
  end

  assign pmp_pmpcfg     = cfg_q;
  assign pmp_mseccfg    = {rlb_q, mmwp_q, mml_q};
  assign pmp_update     = update_q;
  assign pmp_locked_cnt = locked_cnt_q;

endmodule

// File: tb/tb_el2_dec_epmp_ctl.sv
// Directed and randomized checks of el2_dec_epmp_ctl (16 entries, G=2) against
// a per-CSR behavioural model of the PMP/ePMP rules.
module tb_el2_dec_epmp_ctl;
  localparam int NENT = 16;
  localparam int GRAN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [11:0]   wraddr = '0;
  logic [31:0]   wrdata = '0;
  logic [11:0]   rdaddr = '0;
  logic          hit;
  logic [31:0]   rddata;
  logic [127:0]  o_cfg;
  logic [511:0]  o_addr;
  logic [2:0]    o_sec;
  logic          o_upd;
  logic [6:0]    o_lcnt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_cfg[64];
  logic [31:0] m_addr[64];
  logic        m_mml, m_mmwp, m_rlb;

  always #5 clk = ~clk;

  el2_dec_epmp_ctl #(.PMP_ENTRIES(NENT), .PMP_GRAN(GRAN), .PHYS_ADDR_W(32), .SMEPMP_EN(1)) dut (
    .clk(clk), .rst(rst),
    .dec_csr_wen_r_mod(wen), .dec_csr_wraddr_r(wraddr), .dec_csr_wrdata_r(wrdata),
    .dec_csr_rdaddr_d(rdaddr), .dec_pmp_read_d(hit), .dec_pmp_rddata_d(rddata),
    .pmp_pmpcfg(o_cfg), .pmp_pmpaddr(o_addr), .pmp_mseccfg(o_sec),
    .pmp_update(o_upd), .pmp_locked_cnt(o_lcnt)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < 64; e++) begin
      m_cfg[e]  = 8'h00;
      m_addr[e] = 32'h0;
    end
    m_mml = 1'b0; m_mmwp = 1'b0; m_rlb = 1'b0;
  endtask

  function automatic bit locked(input int e);
    return m_cfg[e][7] && !m_rlb;
  endfunction

  function automatic logic [6:0] model_lcnt();
    int n = 0;
    for (int e = 0; e < NENT; e++) n += int'(m_cfg[e][7]);
    return 7'(n);
  endfunction

  function automatic bit exp_hit(input logic [11:0] a);
    return (a >= 12'h3A0 && a <= 12'h3EF) || a == 12'h747 || a == 12'h757;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    int any_l = 0;
    for (int e = 0; e < NENT; e++) any_l += int'(m_cfg[e][7]);
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      for (int j = 0; j < 4; j++) begin
        int e = int'(a - 12'h3A0) * 4 + j;
        logic [7:0] b = d[8*j +: 8];
        b[6:5] = 2'b00;
        if (e < NENT && !locked(e) && !(b[1] && !b[0] && !m_mml)) begin
          if (GRAN >= 1 && b[4:3] == 2'd2) b[4:3] = 2'd0;
          m_cfg[e] = b;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      int e = int'(a - 12'h3B0);
      if (e < NENT && !locked(e) &&
          !(e + 1 < NENT && locked(e + 1) && m_cfg[e+1][4:3] == 2'd1))
        m_addr[e] = d & 32'h3FFF_FFFF;
    end else if (a == 12'h747) begin
      m_mml  = m_mml | d[0];
      m_mmwp = m_mmwp | d[1];
      if (m_rlb || any_l == 0) m_rlb = d[2];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] r = 32'h0;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      for (int j = 0; j < 4; j++) begin
        int e = int'(a - 12'h3A0) * 4 + j;
        if (e < NENT) r[8*j +: 8] = m_cfg[e];
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      int e = int'(a - 12'h3B0);
      if (e < NENT) begin
        r = m_addr[e];
        if (GRAN >= 2) begin
          if (m_cfg[e][4:3] == 2'd3) r = r | ((32'd1 << (GRAN - 1)) - 1);
          else if (m_cfg[e][4:3] != 2'd2) r = r & ~((32'd1 << GRAN) - 1);
        end
      end
    end else if (a == 12'h747) begin
      r = {29'd0, m_rlb, m_mmwp, m_mml};
    end
    return r;
  endfunction

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [7:0]  oc[64];
    logic [31:0] oa[64];
    logic [2:0]  os;
    logic        ch = 1'b0;
    @(negedge clk);
    wen = 1'b1; wraddr = a; wrdata = d; rdaddr = a;
    #1;
    chk("rd_before_commit", rddata, model_read(a));
    oc = m_cfg; oa = m_addr; os = {m_rlb, m_mmwp, m_mml};
    model_write(a, d);
    for (int e = 0; e < 64; e++) ch = ch | (oc[e] != m_cfg[e]) | (oa[e] != m_addr[e]);
    ch = ch | (os != {m_rlb, m_mmwp, m_mml});
    @(posedge clk); #1;
    wen = 1'b0;
    chk("update", o_upd, ch);
    chk("locked_cnt", o_lcnt, model_lcnt());
    chk("rd_after_commit", rddata, model_read(a));
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    rdaddr = a;
    #1;
    chk({tag, "_hit"}, hit, exp_hit(a));
    chk(tag, rddata, exp);
  endtask

  task automatic idle_chk();
    @(posedge clk); #1;
    chk("update_drops", o_upd, 1'b0);
  endtask

  task automatic chk_outs();
    logic [127:0] ec = '0;
    logic [511:0] ea = '0;
    for (int e = 0; e < NENT; e++) begin
      ec[8*e +: 8]  = m_cfg[e];
      ea[32*e +: 32] = m_addr[e];
    end
    chk("pmpcfg_out", o_cfg, ec);
    chk("pmpaddr_out", o_addr, ea);
    chk("mseccfg_out", o_sec, {m_rlb, m_mmwp, m_mml});
  endtask

  task automatic do_reset(input bit midwrite);
    @(negedge clk);
    if (midwrite) begin
      wen = 1'b1; wraddr = 12'h3A0; wrdata = 32'h0000_0F0F;
    end
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_update", o_upd, 1'b0);
    chk("rst_lcnt", o_lcnt, 7'd0);
    chk_outs();
    @(negedge clk);
    wen = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    // reset state
    rd(12'h3A0, 32'h0, "rst_cfg0");
    rd(12'h3B5, 32'h0, "rst_addr5");
    rd(12'h747, 32'h0, "rst_msec");
    chk("rst_update", o_upd, 1'b0);
    chk("rst_lcnt", o_lcnt, 7'd0);

    // basic cfg write, lock survives later write
    wr(12'h3A0, 32'h0000_8F1B);
    rd(12'h3A0, 32'h0000_8F1B, "cfg0_wr");
    chk("lcnt_one", o_lcnt, 7'd1);
    idle_chk();
    wr(12'h3A0, 32'h0);
    rd(12'h3A0, 32'h0000_8F00, "cfg0_locked_keep");

    // TOR lock protects pmpaddr below
    wr(12'h3A0, 32'h8900_0000);
    rd(12'h3A0, 32'h8900_8F00, "cfg0_tor");
    wr(12'h3B2, 32'h1234);
    rd(12'h3B2, 32'h0, "addr2_tor_locked");
    chk("no_upd_ignored", o_upd, 1'b0);
    wr(12'h3B3, 32'h1);
    rd(12'h3B3, 32'h0, "addr3_locked");

    // W-only reserved unless MML; MML sticky
    wr(12'h3A0, 32'h0000_0002);
    rd(12'h3A0, 32'h8900_8F00, "wonly_ignored");
    wr(12'h747, 32'h1);
    rd(12'h747, 32'h1, "mml_set");
    wr(12'h3A0, 32'h0000_0002);
    rd(12'h3A0, 32'h8900_8F02, "wonly_mml");
    wr(12'h747, 32'h0);
    rd(12'h747, 32'h1, "mml_sticky");

    // unimplemented entries
    wr(12'h3A4, 32'hFFFF_FFFF);
    rd(12'h3A4, 32'h0, "unimpl_cfg");
    wr(12'h3C0, 32'h5);
    rd(12'h3C0, 32'h0, "unimpl_addr");
    rd(12'h757, 32'h0, "mseccfgh");
    rd(12'h300, 32'h0, "nonpmp");

    // RLB rules (reset lands mid-write, which is lost)
    do_reset(1'b1);
    rd(12'h3A0, 32'h0, "midwrite_lost");
    wr(12'h747, 32'h4);
    rd(12'h747, 32'h4, "rlb_set");
    wr(12'h3A1, 32'h0000_8100);
    rd(12'h3A1, 32'h0000_8100, "cfg5_lock");
    wr(12'h3B5, 32'hABC);
    rd(12'h3B5, 32'hABC, "rlb_addr5");
    wr(12'h747, 32'h0);
    rd(12'h747, 32'h0, "rlb_clear");
    wr(12'h747, 32'h4);
    rd(12'h747, 32'h0, "rlb_blocked");
    wr(12'h3B5, 32'h111);
    rd(12'h3B5, 32'hABC, "addr5_locked");

    // granularity G=2
    wr(12'h3A1, 32'h0011_8100);
    rd(12'h3A1, 32'h0001_8100, "na4_to_off");
    wr(12'h3A1, 32'h0019_8100);
    wr(12'h3B6, 32'h100);
    rd(12'h3B6, 32'h101, "napot_rb");
    wr(12'h3A1, 32'h0009_8100);
    rd(12'h3B6, 32'h100, "tor_rb");
    chk_outs();

    // randomized traffic against the model
    for (int it = 0; it < 240; it++) begin
      int k = int'($urandom_range(0, 9));
      if (it == 120) do_reset(1'b0);
      if (k <= 3) begin
        a = 12'h3A0 + 12'($urandom_range(0, 5));
        d = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h7F7F_7F7F);
      end else if (k <= 6) begin
        a = 12'h3B0 + 12'($urandom_range(0, 19));
        d = $urandom;
      end else if (k == 7) begin
        a = 12'h747;
        d = $urandom & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h4);
      end else begin
        a = 12'($urandom);
        d = $urandom;
      end
      wr(a, d);
      chk_outs();
      a = ($urandom_range(0, 1) == 0) ? (12'h3A0 + 12'($urandom_range(0, 79))) : 12'($urandom);
      rd(a, model_read(a), "rnd_rd");
      if ($urandom_range(0, 3) == 0) idle_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/el2_dec_epmp_ctl.md
Name: el2_dec_epmp_ctl

Overview:
Parametrised PMP/ePMP CSR block for the VeeR-EL2 decode/TLU CSR path.
- Holds pmpcfg, pmpaddr and mseccfg state.
- Enforces the locking rules and WARL legalisation, including TOR lock propagation, Smepmp MML/MMWP/RLB and granularity G.
- Drives legalised entry state and a registered update strobe to the IFU/LSU PMP checkers.
- Supplies combinational CSR read data to the decode-stage CSR mux.

Parameters:
PMP_ENTRIES, 16, implemented entries; legal values 0, 16, 64.
PMP_GRAN, 0, granularity G; region size 2^(G+2) bytes.
PHYS_ADDR_W, 32, physical address width; pmpaddr keeps bits [PHYS_ADDR_W-3:0], upper bits read 0.
SMEPMP_EN, 1, implements mseccfg; when 0, mseccfg reads 0 and writes are ignored.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
dec_csr_wen_r_mod  in  1  CSR write enable, r-stage
dec_csr_wraddr_r  in  12  CSR write address
dec_csr_wrdata_r  in  32  CSR write data
dec_csr_rdaddr_d  in  12  CSR read address, d-stage
dec_pmp_read_d  out  1  read address hits a PMP/mseccfg CSR
dec_pmp_rddata_d  out  32  read data, combinational
pmp_pmpcfg  out  8xPMP_ENTRIES  legalised cfg per entry {L,0,0,A[1:0],X,W,R}
pmp_pmpaddr  out  32xPMP_ENTRIES  stored pmpaddr per entry, zero-extended
pmp_mseccfg  out  3  {RLB,MMWP,MML}
pmp_update  out  1  one-cycle pulse, cycle after any accepted state change
pmp_locked_cnt  out  7  number of entries with L=1

Behaviour:
- Reset: all cfg, addr, mseccfg, pmp_locked_cnt = 0; pmp_update = 0. Reset may assert mid-write; the write is lost.
- Address map: pmpcfg0-15 at 0x3A0-0x3AF, 4 entries per CSR, entry 4k+j in bits [8j+7:8j]. pmpaddr0-63 at 0x3B0-0x3EF. mseccfg at 0x747; mseccfgh at 0x757 reads 0.
- Unimplemented entries (index >= PMP_ENTRIES) read 0 and ignore writes; dec_pmp_read_d is still asserted for them.
- Writes commit at the clk edge when dec_csr_wen_r_mod=1. Read data reflects state updated by all earlier edges; no bypass.
- Entry locked: lk[i] = cfg[i].L & ~RLB.
- cfg byte write to entry i, ignored if lk[i]. Otherwise the byte is legalised:
  - bits[6:5] forced 0;
  - if W=1 & R=0 & ~(MML & SMEPMP_EN), the whole byte is ignored and the old value kept;
  - if PMP_GRAN>=1 and A=NA4, A is stored as OFF.
- Each byte of one pmpcfg write is judged independently.
- pmpaddr[i] write ignored if lk[i], or if i+1<PMP_ENTRIES & lk[i+1] & cfg[i+1].A==TOR.
- pmpaddr readback with G>=2:
  - A=NAPOT: bits [G-2:0] read 1;
  - A=OFF or TOR: bits [G-1:0] read 0.
  - Stored bits are never altered by this masking.
- mseccfg:
  - MML and MMWP are sticky: set by writing 1, cleared only by rst.
  - RLB is writable only while RLB=1 or no entry has L=1; otherwise the RLB bit of the write is ignored.
  - MML and MMWP still apply from the same write.
- When RLB=1, locked entries are fully writable, and L may be cleared.
- pmp_update: registered OR of "any register value changed" at the previous edge. An ignored write or a same-value write gives no pulse.
- pmp_locked_cnt: registered popcount of cfg L bits, updated one cycle after the change, consistent with pmp_update.
- Simultaneous write and read of the same CSR: read returns the old value.

Test Plan:
1. Reset, then read 0x3A0, 0x3B5 and 0x747 -> all read 0; pmp_update=0; pmp_locked_cnt=0.
2. Write 0x3A0=0x0000_8F1B -> entry0 cfg=0x1B, entry1 cfg=0x8F, entry2/3=0x00; pmp_update pulses one cycle later; locked_cnt=1. Then write 0x3A0=0 -> entry1 stays 0x8F.
3. Set entry3 cfg=0x89 (L, TOR, R); write pmpaddr2=0x1234 -> ignored, reads old value, no pmp_update. Write pmpaddr3=0x1 -> ignored.
4. Write byte 0x02 (W only) to entry0 with MML=0 -> byte ignored. Set mseccfg=0x1, repeat -> entry0 cfg=0x02. Write mseccfg=0 -> MML still reads 1.
5. With no L bits, write mseccfg=0x4 -> RLB=1. Lock entry5, write pmpaddr5=0xABC -> accepted. Write mseccfg=0 -> RLB=0. Write mseccfg=0x4 -> RLB stays 0.
6. PMP_GRAN=2: write NA4 cfg -> A reads OFF. Set A=NAPOT, pmpaddr=0x100 -> reads 0x101. Set A=TOR -> reads 0x100.
